phase_lock: RTL and testbench

//  Sits directly downstream of the clock-recovery phase estimator (sample-clock domain).

---
 rtl/phase_lock_pkg.sv | 23 ++
 rtl/phase_lock_distance.sv | 40 ++++
 rtl/phase_lock.sv | 177 +++++++++++++++++
 tb/tb_phase_lock.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_lock_pkg.sv
// Shared types and defaults for the phase_lock block: FSM state encoding, parameter
// defaults and the width used for signed circular phase differences.
package phase_lock_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSeek  = 2'd1,
        StLock  = 2'd2,
        StError = 2'd3
    } state_e;

    localparam int unsigned DefRatio  = 12;
    localparam int unsigned DefRbits  = 4;
    localparam int unsigned DefCount  = 3;
    localparam int unsigned DefCbits  = 2;
    localparam int unsigned DefWindow = 1;

    // One extra bit so a phase difference keeps its sign.
    function automatic int unsigned dist_width(input int unsigned rbits);
        return rbits + 1;
    endfunction

endpackage

// File: rtl/phase_lock_distance.sv
// Combinational circular phase difference folded into -HALF..RATIO-1-HALF, plus a flag
// telling whether its magnitude lies within WINDOW.
module phase_lock_distance
    import phase_lock_pkg::*;
#(
    parameter int unsigned RATIO  = DefRatio,
    parameter int unsigned RBITS  = DefRbits,
    parameter int unsigned WINDOW = DefWindow
) (
    input  logic [RBITS-1:0]      i_phase,
    input  logic [RBITS-1:0]      i_ref,
    output logic signed [RBITS:0] o_dist,
    output logic                  o_in_window
);

    localparam int unsigned DW   = dist_width(RBITS);
    localparam int unsigned HALF = (RATIO - 1) >> 1;

    localparam logic signed [DW-1:0] RatioS = DW'(RATIO);
    localparam logic signed [DW-1:0] HiS    = DW'(RATIO - 1 - HALF);
    localparam logic signed [DW-1:0] LoS    = DW'(-int'(HALF));
    localparam logic signed [DW-1:0] WinS   = DW'(WINDOW);

    logic signed [DW-1:0] w_raw;
    logic signed [DW-1:0] w_abs;

    always_comb begin
        w_raw  = $signed({1'b0, i_phase}) - $signed({1'b0, i_ref});
        o_dist = w_raw;
        // Raw difference spans +/-RMAX, so one correction by RATIO always suffices.
        if (w_raw > HiS) begin
            o_dist = w_raw - RatioS;
        end else if (w_raw < LoS) begin
            o_dist = w_raw + RatioS;
        end
        w_abs       = o_dist[RBITS] ? -o_dist : o_dist;
        o_in_window = (w_abs <= WinS);
    end

endmodule

// File: rtl/phase_lock.sv
// Qualifies per-edge phase estimates into a lock decision, flags loss of lock and emits a
// mid-bit sample strobe. Define PHASE_LOCK_DRIFT_EN to let the locked phase track drift.
module phase_lock
    import phase_lock_pkg::*;
#(
    parameter int unsigned RATIO  = DefRatio,
    parameter int unsigned RBITS  = DefRbits,
    parameter int unsigned COUNT  = DefCount,
    parameter int unsigned CBITS  = DefCbits,
    parameter int unsigned WINDOW = DefWindow
) (
    input  logic             clk_s_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             start_i,
    input  logic             update_i,
    input  logic [RBITS-1:0] phase_i,
    input  logic             retry_i,
    output logic [RBITS-1:0] phase_o,
    output logic             strobe_o,
    output logic             valid_o,
    output logic             error_o
);

    localparam int unsigned DW   = dist_width(RBITS);
    localparam int unsigned RMAX = RATIO - 1;
    localparam int unsigned HALF = RMAX >> 1;

    localparam logic [RBITS-1:0] RmaxV  = RBITS'(RMAX);
    localparam logic [RBITS-1:0] OneR   = RBITS'(1);
    localparam logic [DW-1:0]    HalfW  = DW'(HALF);
    localparam logic [DW-1:0]    RatioW = DW'(RATIO);
    localparam logic [CBITS-1:0] CountV = CBITS'(COUNT);
    localparam logic [CBITS-1:0] OneC   = CBITS'(1);

    state_e               r_state, w_state_nxt;
    logic [RBITS-1:0]     r_ref, w_ref_nxt;
    logic [RBITS-1:0]     r_phase, w_phase_nxt;
    logic [RBITS-1:0]     r_cnt, w_cnt_nxt;
    logic [CBITS-1:0]     r_hits, w_hits_nxt;
    logic [CBITS-1:0]     r_misses, w_misses_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_error, w_error_nxt;
    logic                 r_strobe, w_strobe_nxt;
    logic [CBITS-1:0]     w_hits_inc, w_misses_inc;
    logic [DW-1:0]        w_sum;
    logic [RBITS-1:0]     w_target;
    logic signed [DW-1:0] w_dist;
    logic                 w_in_window;

    phase_lock_distance #(
        .RATIO  (RATIO),
        .RBITS  (RBITS),
        .WINDOW (WINDOW)
    ) u_distance (
        .i_phase     (phase_i),
        .i_ref       (r_ref),
        .o_dist      (w_dist),
        .o_in_window (w_in_window)
    );

`ifdef PHASE_LOCK_DRIFT_EN
    logic [RBITS-1:0] w_ref_up, w_ref_dn;
    assign w_ref_up = (r_ref == RmaxV) ? '0 : r_ref + OneR;
    assign w_ref_dn = (r_ref == '0) ? RmaxV : r_ref - OneR;
`else
    logic w_unused_dist;
    assign w_unused_dist = ^w_dist;
`endif

    assign w_hits_inc   = r_hits + OneC;
    assign w_misses_inc = r_misses + OneC;
    assign w_cnt_nxt    = start_i ? '0 : ((r_cnt == RmaxV) ? '0 : r_cnt + OneR);
    assign w_sum        = {1'b0, r_phase} + HalfW;
    assign w_target     = (w_sum >= RatioW) ? RBITS'(w_sum - RatioW) : w_sum[RBITS-1:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_ref_nxt    = r_ref;
        w_phase_nxt  = r_phase;
        w_hits_nxt   = r_hits;
        w_misses_nxt = r_misses;
        w_valid_nxt  = r_valid;
        w_error_nxt  = r_error;
        if (!enable_i) begin
            w_state_nxt  = StIdle;
            w_ref_nxt    = '0;
            w_phase_nxt  = '0;
            w_hits_nxt   = '0;
            w_misses_nxt = '0;
            w_valid_nxt  = 1'b0;
            w_error_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: w_state_nxt = StSeek;
                StSeek: begin
                    if (update_i) begin
                        if (r_hits != '0 && w_in_window) begin
                            w_hits_nxt = w_hits_inc;
                            if (w_hits_inc == CountV) begin
                                w_state_nxt  = StLock;
                                w_phase_nxt  = r_ref;
                                w_valid_nxt  = 1'b1;
                                w_misses_nxt = '0;
                            end
                        end else begin
                            w_ref_nxt  = phase_i;
                            w_hits_nxt = OneC;
                        end
                    end
                end
                StLock: begin
                    if (update_i) begin
                        if (w_in_window) begin
                            w_misses_nxt = '0;
`ifdef PHASE_LOCK_DRIFT_EN
                            if (w_dist != '0) begin
                                w_ref_nxt   = w_dist[RBITS] ? w_ref_dn : w_ref_up;
                                w_phase_nxt = w_dist[RBITS] ? w_ref_dn : w_ref_up;
                            end
`endif
                        end else begin
                            w_misses_nxt = w_misses_inc;
                            if (w_misses_inc == CountV) begin
                                w_state_nxt = StError;
                                w_valid_nxt = 1'b0;
                                w_error_nxt = 1'b1;
                            end
                        end
                    end
                end
                StError: begin
                    // Retry wins over any update arriving in the same cycle.
                    if (retry_i) begin
                        w_state_nxt  = StSeek;
                        w_error_nxt  = 1'b0;
                        w_hits_nxt   = '0;
                        w_misses_nxt = '0;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
        // Suppressed when valid is about to drop so no strobe trails a lost lock.
        w_strobe_nxt = r_valid && w_valid_nxt && (r_cnt == w_target);
    end

    always_ff @(posedge clk_s_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= StIdle;
            r_ref    <= '0;
            r_phase  <= '0;
            r_cnt    <= '0;
            r_hits   <= '0;
            r_misses <= '0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ref    <= w_ref_nxt;
            r_phase  <= w_phase_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hits   <= w_hits_nxt;
            r_misses <= w_misses_nxt;
            r_valid  <= w_valid_nxt;
            r_error  <= w_error_nxt;
            r_strobe <= w_strobe_nxt;
        end
    end

    assign phase_o  = r_phase;
    assign strobe_o = r_strobe;
    assign valid_o  = r_valid;
    assign error_o  = r_error;

endmodule

// File: tb/tb_phase_lock.sv
// Scoreboard bench for phase_lock: directed scenarios plus randomized estimates, checked
// cycle by cycle against a behavioural lock model kept in the bench.
module tb_phase_lock;

    localparam int Ratio  = 12;
    localparam int Half   = 5;
    localparam int Count  = 3;
    localparam int Window = 1;

    localparam int ModeIdle  = 0;
    localparam int ModeSeek  = 1;
    localparam int ModeLock  = 2;
    localparam int ModeError = 3;

    logic       clk_s_i = 1'b0;
    logic       reset_i;
    logic       enable_i;
    logic       start_i;
    logic       update_i;
    logic [3:0] phase_i;
    logic       retry_i;
    logic [3:0] phase_o;
    logic       strobe_o;
    logic       valid_o;
    logic       error_o;

    always #5 clk_s_i = ~clk_s_i;

    phase_lock dut (
        .clk_s_i  (clk_s_i),
        .reset_i  (reset_i),
        .enable_i (enable_i),
        .start_i  (start_i),
        .update_i (update_i),
        .phase_i  (phase_i),
        .retry_i  (retry_i),
        .phase_o  (phase_o),
        .strobe_o (strobe_o),
        .valid_o  (valid_o),
        .error_o  (error_o)
    );

    typedef struct packed {
        logic [3:0] phase;
        logic       strobe;
        logic       valid;
        logic       error;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_e, mon_a;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    int m_mode, m_ref, m_hits, m_miss, m_cnt, m_phase;
    bit m_valid, m_error, m_strobe;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = ModeIdle; m_ref = 0; m_hits = 0; m_miss = 0; m_cnt = 0; m_phase = 0;
        m_valid = 0; m_error = 0; m_strobe = 0;
    endtask

    // Signed circular distance in -Half..Ratio-1-Half.
    function automatic int circ(input int p, input int r);
        int d;
        d = (((p - r) % Ratio) + Ratio) % Ratio;
        if (d > Ratio - 1 - Half) d -= Ratio;
        return d;
    endfunction

    task automatic model_step(input bit en, input bit st, input bit upd, input bit rt,
                              input int ph);
        int n_mode, n_ref, n_hits, n_miss, n_phase, n_cnt, d, tgt;
        bit n_valid, n_error, inw;
        obs_t e;
        n_mode = m_mode; n_ref = m_ref; n_hits = m_hits; n_miss = m_miss; n_phase = m_phase;
        n_valid = m_valid; n_error = m_error;
        n_cnt = st ? 0 : (m_cnt + 1) % Ratio;
        tgt   = (m_phase + Half) % Ratio;
        d     = circ(ph, m_ref);
        inw   = (d <= Window) && (d >= -Window);
        if (!en) begin
            n_mode = ModeIdle; n_ref = 0; n_hits = 0; n_miss = 0; n_phase = 0;
            n_valid = 0; n_error = 0;
        end else if (m_mode == ModeIdle) begin
            n_mode = ModeSeek;
        end else if (m_mode == ModeError) begin
            if (rt) begin
                n_mode = ModeSeek; n_error = 0; n_hits = 0; n_miss = 0;
            end
        end else if (upd) begin
            if (m_mode == ModeSeek) begin
                if (m_hits == 0 || !inw) begin
                    n_ref = ph; n_hits = 1;
                end else begin
                    n_hits = m_hits + 1;
                    if (n_hits == Count) begin
                        n_mode = ModeLock; n_phase = m_ref; n_valid = 1; n_miss = 0;
                    end
                end
            end else if (inw) begin
                n_miss = 0;
`ifdef PHASE_LOCK_DRIFT_EN
                if (d != 0) begin
                    n_ref   = (m_ref + ((d > 0) ? 1 : -1) + Ratio) % Ratio;
                    n_phase = n_ref;
                end
`endif
            end else begin
                n_miss = m_miss + 1;
                if (n_miss == Count) begin
                    n_mode = ModeError; n_valid = 0; n_error = 1;
                end
            end
        end
        m_strobe = m_valid && n_valid && (m_cnt == tgt);
        m_mode = n_mode; m_ref = n_ref; m_hits = n_hits; m_miss = n_miss; m_phase = n_phase;
        m_cnt = n_cnt; m_valid = n_valid; m_error = n_error;
        e.phase  = 4'(m_phase);
        e.strobe = m_strobe;
        e.valid  = m_valid;
        e.error  = m_error;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit en, input bit upd, input bit rt, input int ph);
        bit st;
        st       = (cyc % Ratio) == 0;
        enable_i = en;
        start_i  = st;
        update_i = upd;
        retry_i  = rt;
        phase_i  = 4'(ph);
        @(posedge clk_s_i);
        model_step(en, st, upd, rt, ph);
        cyc++;
        @(negedge clk_s_i);
    endtask

    task automatic upd_est(input int ph);
        step(1, 1, 0, ph);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
    endtask

    task automatic count_strobes(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            step(1, 0, 0, 0);
            if (strobe_o) n++;
        end
    endtask

    always @(negedge clk_s_i) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {phase_o, strobe_o, valid_o, error_o};
            n_vec++;
            if (mon_a !== mon_e) begin
                n_err++;
                $display("FAIL cycle_%0d: got phase=%0d strobe=%0b valid=%0b error=%0b, expected phase=%0d strobe=%0b valid=%0b error=%0b",
                         cyc, mon_a.phase, mon_a.strobe, mon_a.valid, mon_a.error,
                         mon_e.phase, mon_e.strobe, mon_e.valid, mon_e.error);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        int n, c, j, jit;
        reset_i = 1; enable_i = 0; start_i = 0; update_i = 0; retry_i = 0; phase_i = 0;
        model_reset();
        repeat (2) @(negedge clk_s_i);
        chk("reset_phase", phase_o, 0);
        chk("reset_valid", valid_o, 0);
        chk("reset_error", error_o, 0);
        chk("reset_strobe", strobe_o, 0);
        #2 reset_i = 0;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        // Lock on 5,5,6.
        upd_est(5); upd_est(5);
        chk("seek_no_valid", valid_o, 0);
        upd_est(6);
        chk("lock_valid", valid_o, 1);
        chk("lock_phase", phase_o, 5);
        count_strobes(24, n);
        chk("strobe_count_lock5", n, 2);

        // Small in-window deviation while locked.
        upd_est(6);
`ifdef PHASE_LOCK_DRIFT_EN
        chk("drift_phase", phase_o, 6);
`else
        chk("frozen_phase_1", phase_o, 5);
`endif
        upd_est(6);
`ifndef PHASE_LOCK_DRIFT_EN
        chk("frozen_phase_2", phase_o, 5);
`endif
        chk("lock_still_valid", valid_o, 1);

        // Three misses lose lock.
        upd_est(2); upd_est(2);
        chk("two_misses_valid", valid_o, 1);
        upd_est(2);
        chk("loss_error", error_o, 1);
        chk("loss_valid", valid_o, 0);
        count_strobes(24, n);
        chk("strobe_count_error", n, 0);
`ifndef PHASE_LOCK_DRIFT_EN
        chk("error_hold_phase", phase_o, 5);
`endif
        step(1, 1, 1, 7);
        step(1, 0, 0, 0);
        chk("retry_error", error_o, 0);
        upd_est(7); upd_est(7);
        chk("reacq_not_yet", valid_o, 0);
        upd_est(7);
        chk("reacq_valid", valid_o, 1);
        chk("reacq_phase", phase_o, 7);

        // Async reset while a strobe is showing.
        n = 0;
        for (int i = 0; i < 24 && n == 0; i++) begin
            step(1, 0, 0, 0);
            if (strobe_o) n = 1;
        end
        chk("strobe_seen_before_reset", n, 1);
        #2 reset_i = 1;
        #1;
        chk("async_phase", phase_o, 0);
        chk("async_valid", valid_o, 0);
        chk("async_error", error_o, 0);
        chk("async_strobe", strobe_o, 0);
        @(posedge clk_s_i);
        @(negedge clk_s_i);
        #2 reset_i = 0;
        model_reset();

        // Lock across the wrap point.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        upd_est(11); upd_est(0); upd_est(11);
        chk("wrap_valid", valid_o, 1);
        chk("wrap_phase", phase_o, 11);
        count_strobes(24, n);
        chk("strobe_count_wrap", n, 2);

        // Restart on an out-of-window estimate, then disable.
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        upd_est(5); upd_est(9); upd_est(9);
        chk("restart_not_yet", valid_o, 0);
        upd_est(9);
        chk("restart_valid", valid_o, 1);
        chk("restart_phase", phase_o, 9);
        step(0, 0, 0, 0);
        chk("disable_valid", valid_o, 0);
        chk("disable_phase", phase_o, 0);
        chk("disable_error", error_o, 0);
        chk("disable_strobe", strobe_o, 0);

        // Randomized estimates clustered around a slowly changing centre.
        c = $urandom_range(0, 11);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) c = $urandom_range(0, 11);
            j   = $urandom_range(0, 9);
            jit = (j < 5) ? 0 : (j < 7) ? 1 : (j < 9) ? -1 : 3;
            step($urandom_range(0, 149) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 29) == 0, (c + jit + Ratio) % Ratio);
        end
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
